keypad_digit_entry: RTL and testbench

- Upstream stage of the microwave cook-time timer.
- Debounces the ten digit keys and the clear key, encodes the pressed digit to BCD, and emits a single-cycle load strobe per accepted press.
- The timer shifts the digit in: units → seconds-tens → minutes.
- Keeps a shadow copy of the three entered digits to reject entries the timer cannot represent (seconds-tens > 5, more than 3 digits) and to report entry progress.

---
 rtl/keypad_digit_entry.sv | 138 +++++++++++++
 tb/tb_keypad_digit_entry.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_digit_entry.sv
// Keypad front end for the cook-time timer: debounces digit/clear keys and strobes accepted digits.
// Optional macro KEYPAD_RANGE_CHECK_EN rejects a seconds-tens digit above 5.
module keypad_digit_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  keys,
  input  logic        key_clear,
  input  logic        lock,
  output logic [3:0]  digit,
  output logic        load,
  output logic        clear_out,
  output logic        err,
  output logic [1:0]  digit_count,
  output logic [11:0] shadow
);

  localparam int unsigned NUM_LINES  = 11;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned CLEAR_CODE = 10;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, COMMIT, RELEASE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [NUM_LINES-1:0] lines;
  logic                single_key;
  logic                any_key;
  logic [CODE_W-1:0]   line_code;
  logic                range_bad;
  logic                reject;

  logic [3:0]  digit_d;
  logic        load_d, clear_d, err_d;
  logic [1:0]  count_d;
  logic [11:0] shadow_d;

  assign lines      = {key_clear, keys};
  assign single_key = $onehot(lines);
  assign any_key    = |lines;

  // Encoder is only meaningful when exactly one line is high.
  always_comb begin
    line_code = '0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      if (lines[i]) line_code = CODE_W'(i);
    end
  end

`ifdef KEYPAD_RANGE_CHECK_EN
  assign range_bad = (digit_count != 2'd0) && (shadow[3:0] > 4'd5);
`else
  assign range_bad = 1'b0;
`endif

  assign reject = lock || (digit_count == 2'd3) || range_bad;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      digit       <= '0;
      load        <= 1'b0;
      clear_out   <= 1'b0;
      err         <= 1'b0;
      digit_count <= '0;
      shadow      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= code_d;
      digit       <= digit_d;
      load        <= load_d;
      clear_out   <= clear_d;
      err         <= err_d;
      digit_count <= count_d;
      shadow      <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    digit_d  = digit;
    load_d   = 1'b0;
    clear_d  = 1'b0;
    err_d    = 1'b0;
    count_d  = digit_count;
    shadow_d = shadow;

    case (state_q)
      IDLE: begin
        if (single_key) begin
          code_d  = line_code;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (single_key && (line_code == code_q)) begin
          if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) state_d = COMMIT;
          else cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT: begin
        state_d = RELEASE;
        cnt_d   = '0;
        // Clear is honoured regardless of lock.
        if (code_q == CODE_W'(CLEAR_CODE)) begin
          clear_d  = 1'b1;
          shadow_d = '0;
          count_d  = '0;
        end else if (reject) begin
          err_d = 1'b1;
        end else begin
          load_d   = 1'b1;
          digit_d  = code_q;
          shadow_d = {shadow[7:0], code_q};
          count_d  = digit_count + 2'd1;
        end
      end
      RELEASE: begin
        if (any_key) cnt_d = '0;
        else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Scoreboard bench for keypad_digit_entry: a bench-side entry model predicts each strobe and its cycle.
module tb_keypad_digit_entry;

  localparam int DEB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  keys;
  logic        key_clear;
  logic        lock;
  logic [3:0]  digit;
  logic        load;
  logic        clear_out;
  logic        err;
  logic [1:0]  digit_count;
  logic [11:0] shadow;

  keypad_digit_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .keys(keys), .key_clear(key_clear), .lock(lock),
    .digit(digit), .load(load), .clear_out(clear_out), .err(err),
    .digit_count(digit_count), .shadow(shadow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          kind;   // 0 load, 1 clear, 2 err
    int          cyc;
    logic [3:0]  digit;
    logic [11:0] shadow;
    logic [1:0]  count;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [3:0]  m_digit;
  logic [11:0] m_shadow;
  logic [1:0]  m_count;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pop and compare whenever the DUT raises any strobe.
  always @(negedge clock) begin : monitor
    exp_t e;
    int   kind;
    if (load || clear_out || err) begin
      check("strobe_excl", $countones({load, clear_out, err}), 1);
      if (q.size() == 0) begin
        check("spurious_strobe", {29'd0, load, clear_out, err}, 0);
      end else begin
        e    = q.pop_front();
        kind = load ? 0 : (clear_out ? 1 : 2);
        check("strobe_kind", kind, e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("digit", digit, e.digit);
        check("shadow", shadow, e.shadow);
        check("digit_count", digit_count, e.count);
      end
    end
  end

  task automatic model_reset();
    m_digit  = '0;
    m_shadow = '0;
    m_count  = '0;
  endtask

  // Drive one key pattern for 'hold' sampling edges, then a clean release.
  task automatic press(input logic [10:0] pat, input int hold);
    exp_t e;
    int   code;
    logic rej;
    @(negedge clock);
    if (hold >= DEB + 1 && $onehot(pat)) begin
      code = 0;
      for (int i = 0; i < 11; i++) if (pat[i]) code = i;
      if (code == 10) begin
        e.kind   = 1;
        m_shadow = '0;
        m_count  = '0;
      end else begin
        rej = lock || (m_count == 2'd3);
`ifdef KEYPAD_RANGE_CHECK_EN
        if (m_count != 2'd0 && m_shadow[3:0] > 4'd5) rej = 1'b1;
`endif
        if (rej) begin
          e.kind = 2;
        end else begin
          e.kind   = 0;
          m_digit  = 4'(code);
          m_shadow = {m_shadow[7:0], 4'(code)};
          m_count  = m_count + 2'd1;
        end
      end
      e.cyc    = cyc + DEB + 2;
      e.digit  = m_digit;
      e.shadow = m_shadow;
      e.count  = m_count;
      q.push_back(e);
    end
    {key_clear, keys} = pat;
    repeat (hold) @(negedge clock);
    {key_clear, keys} = '0;
    repeat (DEB + 6) @(negedge clock);
    check("pending", q.size(), 0);
  endtask

  function automatic logic [10:0] dkey(input int d);
    logic [10:0] one;
    one = 11'd1;
    return one << d;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; keys = '0; key_clear = 1'b0; lock = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_digit", digit, 0);
    check("rst_load", load, 0);
    check("rst_clear", clear_out, 0);
    check("rst_err", err, 0);
    check("rst_count", digit_count, 0);
    check("rst_shadow", shadow, 0);

    // Held key: one load, no repeat while held.
    press(dkey(7), 10);
    // Bounce shorter than debounce window.
    press(dkey(3), 3);
    check("digit_hold", digit, 4'd7);

    press(dkey(10), 8);
    press(dkey(1), 6);
    press(dkey(3), 6);
    press(dkey(0), 6);
    check("shadow_130", shadow, 12'h130);
    check("count_sat", digit_count, 2'd3);
    press(dkey(5), 6);
    check("shadow_after_full", shadow, 12'h130);

    // Seconds-tens range behaviour depends on the build option.
    press(dkey(10), 6);
    press(dkey(8), 6);
    press(dkey(2), 6);
    check("shadow_range", shadow, m_shadow);

    lock = 1'b1;
    press(dkey(4), 6);
    press(dkey(10), 6);
    check("shadow_locked_clear", shadow, 0);
    check("count_locked_clear", digit_count, 0);
    lock = 1'b0;

    // Two keys together is not a valid key.
    press(dkey(2) | dkey(5), 10);
    press(dkey(9), 5);
    check("shadow_9", shadow, 12'h009);

    // Reset mid-debounce aborts the press.
    @(negedge clock);
    keys = 10'd1 << 9;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    keys  = '0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    check("mid_rst_digit", digit, 0);
    check("mid_rst_flags", {load, clear_out, err}, 0);
    check("mid_rst_count", digit_count, 0);
    check("mid_rst_shadow", shadow, 0);
    repeat (DEB + 6) @(negedge clock);
    check("mid_rst_pending", q.size(), 0);

    press(dkey(6), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
